rk4_step_sequencer: RTL and testbench
=====================================

Name: rk4_step_sequencer

Overview:
- Control FSM that sequences a shared RK4 derivative-evaluation datapath (RLC state: charge q, current z) through the four slope stages and the state-commit of each integration step.
- Runs a programmed number of steps per start command.
- Issues per-stage offset and weight selects, accumulator control and a commit strobe.
- Sits between the stimulus/testbench controller and the fixed-point derivative unit plus state registers.

Parameters:
- STEP_W, 16, width of the step count and step counter.
- TIMEOUT, 64, max cycles to wait for eval_ack per stage (used only with RK4_TIMEOUT_EN).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle pulse; begins a run of n_steps steps.
- abort  in  1  terminates the run.
- n_steps  in  STEP_W  number of steps; sampled on an accepted start.
- busy  out  1  high from accepted start until return to IDLE.
- done  out  1  one-cycle pulse when the run completes.
- step_cnt  out  STEP_W  steps committed in the current/last run.
- eval_req  out  1  request to derivative unit.
- eval_stage  out  2  stage index 0..3 (k1..k4).
- offs_sel  out  2  state offset for evaluation: 0 none, 1 dt/2, 2 dt.
- acc_w  out  2  RK4 weight for the stage result: 1,2,2,1.
- eval_ack  in  1  derivative unit result valid.
- acc_clr  out  1  clear weighted-slope accumulator.
- acc_en  out  1  accumulate current result.
- commit  out  1  apply state += dt/6 * acc.
- err  out  1  sticky timeout flag (tied 0 without RK4_TIMEOUT_EN).

Behaviour:
- States: IDLE, EVAL, COMMIT.
- Reset: state IDLE; all outputs 0; step_cnt 0; err 0.
- IDLE:
  - start=1 with n_steps!=0 → EVAL next cycle with stage 0; acc_clr pulses that cycle; step_cnt←0; n_steps latched; busy=1.
  - start=1 with n_steps==0 → done pulses next cycle; stay IDLE; step_cnt←0.
  - start and abort in the same cycle: abort wins; start is ignored.
- EVAL:
  - eval_req=1; eval_stage=s.
  - offs_sel: s0→0, s1→1, s2→1, s3→2.
  - acc_w: s0→1, s1→2, s2→2, s3→1.
  - eval_stage, offs_sel and acc_w are registered and stable while eval_req=1.
  - acc_en = eval_req & eval_ack (combinational, same cycle).
  - On ack with s<3: s←s+1 next cycle; eval_req stays high.
  - On ack with s=3: eval_req drops next cycle; go to COMMIT.
  - eval_ack while eval_req=0 is ignored.
- COMMIT (one cycle):
  - commit=1; step_cnt←step_cnt+1.
  - If the incremented count equals the latched n_steps: next cycle done=1, busy=0, IDLE.
  - Otherwise: next cycle EVAL with s=0; acc_clr pulses in that same transition cycle.
- Per-step latency with zero-wait ack: 5 cycles (4 EVAL + 1 COMMIT).
- start while busy is ignored.
- abort while busy → IDLE next cycle.
  - eval_req, commit, acc_* go 0; no done pulse.
  - step_cnt holds the number of committed steps.
  - abort in the COMMIT cycle still lets that commit occur; step_cnt includes it.
- step_cnt wraps at 2^STEP_W-1 only if n_steps = 0 never matches; n_steps=0 never enters EVAL, so no wrap occurs.
- rst mid-run: immediate return to reset values on the next edge.

Optional Feature:
- Macro: RK4_TIMEOUT_EN.
- With it defined:
  - A wait counter resets on each stage entry and counts cycles with eval_req=1 and eval_ack=0.
  - On reaching TIMEOUT: err←1 (sticky until rst or the next accepted start); FSM → IDLE; no done pulse.
- Without it: EVAL waits indefinitely; err is constant 0; no counter logic.

Test Plan:
- Reset, then idle 10 cycles → all outputs 0, busy=0.
- start, n_steps=3, eval_ack tied 1 →
  - eval_stage sequence 0,1,2,3 ×3; offs_sel 0,1,1,2; acc_w 1,2,2,1.
  - 3 commit pulses 5 cycles apart.
  - done 15 cycles after start+1; step_cnt=3.
- start, n_steps=2, ack delayed 3 cycles per stage → stage fields stable while waiting; acc_en exactly 8 pulses; 2 commits; done.
- start, n_steps=0 → done next cycle; eval_req never asserted. Also start+abort in the same cycle in IDLE → nothing happens.
- n_steps=5, abort during step 3 stage 2 → IDLE next cycle; step_cnt=2; no done. Also start while busy → ignored.
- RK4_TIMEOUT_EN, TIMEOUT=64, ack withheld at stage 1 → err=1 after 64 wait cycles; busy=0; no done. Next start clears err.

Source files
------------

// File: rtl/rk4_step_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : rk4_step_sequencer
// Purpose  : Control FSM for one shared RK4 derivative-evaluation datapath
//            (RLC state: charge q, current z). It steps the datapath through
//            the four slope stages k1..k4, commits the weighted slope sum,
//            and repeats for a programmed number of steps per start command.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            start, n_steps  - run request; n_steps is latched on acceptance
//            abort           - ends a run early (no done pulse)
//            busy, done      - run in progress / one-cycle completion pulse
//            step_cnt        - steps committed in the current or last run
//            eval_req/_ack   - handshake with the derivative unit
//            eval_stage      - stage index 0..3 (k1..k4)
//            offs_sel        - state offset: 0 none, 1 dt/2, 2 dt
//            acc_w           - stage weight 1,2,2,1
//            acc_clr, acc_en - weighted-slope accumulator control
//            commit          - apply state += dt/6 * acc
//            err             - sticky eval_ack timeout flag
// Options  : RK4_TIMEOUT_EN  - enables the per-stage eval_ack timeout
//            (TIMEOUT cycles); otherwise EVAL waits indefinitely, err = 0.
// Revision : 1.0 - initial release
// ============================================================================
module rk4_step_sequencer #(
    parameter int STEP_W  = 16,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [STEP_W-1:0] n_steps,
    output logic              busy,
    output logic              done,
    output logic [STEP_W-1:0] step_cnt,
    output logic              eval_req,
    output logic [1:0]        eval_stage,
    output logic [1:0]        offs_sel,
    output logic [1:0]        acc_w,
    input  logic              eval_ack,
    output logic              acc_clr,
    output logic              acc_en,
    output logic              commit,
    output logic              err
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_EVAL   = 2'd1;
    localparam logic [1:0] S_COMMIT = 2'd2;

    // Per-stage lookup tables, stage 0 in the least significant pair.
    localparam logic [7:0]        c_OFFS_TAB = {2'd2, 2'd1, 2'd1, 2'd0};
    localparam logic [7:0]        c_WGT_TAB  = {2'd1, 2'd2, 2'd2, 2'd1};
    localparam logic [STEP_W-1:0] c_STEP_ONE = STEP_W'(1);

    logic [1:0]        r_state,    w_state_nxt;
    logic [1:0]        r_stage,    w_stage_nxt;
    logic [1:0]        r_offs_sel, w_offs_sel_nxt;
    logic [1:0]        r_acc_w,    w_acc_w_nxt;
    logic [STEP_W-1:0] r_n_steps,  w_n_steps_nxt;
    logic [STEP_W-1:0] r_step_cnt, w_step_cnt_nxt;
    logic              r_done,     w_done_nxt;
    logic              w_acc_clr;
    logic              w_timeout;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_stage    <= 2'd0;
            r_offs_sel <= 2'd0;
            r_acc_w    <= 2'd0;
            r_n_steps  <= '0;
            r_step_cnt <= '0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_stage    <= w_stage_nxt;
            r_offs_sel <= w_offs_sel_nxt;
            r_acc_w    <= w_acc_w_nxt;
            r_n_steps  <= w_n_steps_nxt;
            r_step_cnt <= w_step_cnt_nxt;
            r_done     <= w_done_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_stage_nxt    = r_stage;
        w_offs_sel_nxt = 2'd0;
        w_acc_w_nxt    = 2'd0;
        w_n_steps_nxt  = r_n_steps;
        w_step_cnt_nxt = r_step_cnt;
        w_done_nxt     = 1'b0;
        w_acc_clr      = 1'b0;

        case (r_state)
            S_IDLE: begin
                // abort has priority over a simultaneous start
                if (start && !abort) begin
                    w_step_cnt_nxt = '0;
                    if (n_steps != '0) begin
                        w_state_nxt   = S_EVAL;
                        w_stage_nxt   = 2'd0;
                        w_n_steps_nxt = n_steps;
                        w_acc_clr     = 1'b1;
                    end else begin
                        w_done_nxt = 1'b1;
                    end
                end
            end

            S_EVAL: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else if (eval_ack) begin
                    if (r_stage == 2'd3) begin
                        w_state_nxt = S_COMMIT;
                    end else begin
                        w_stage_nxt = r_stage + 2'd1;
                    end
                end else if (w_timeout) begin
                    w_state_nxt = S_IDLE;
                end
            end

            S_COMMIT: begin
                // The commit strobe is already on the wire this cycle, so the
                // count always includes it, even when aborting.
                w_step_cnt_nxt = r_step_cnt + c_STEP_ONE;
                if (abort) begin
                    w_state_nxt = S_IDLE;
                end else if ((r_step_cnt + c_STEP_ONE) == r_n_steps) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end else begin
                    // Clear in the transition cycle so stage 0 of the next
                    // step can accumulate on its very first cycle.
                    w_state_nxt = S_EVAL;
                    w_stage_nxt = 2'd0;
                    w_acc_clr   = 1'b1;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Stage fields are registered and only non-zero while in EVAL.
        if (w_state_nxt == S_EVAL) begin
            w_offs_sel_nxt = c_OFFS_TAB[{w_stage_nxt, 1'b0} +: 2];
            w_acc_w_nxt    = c_WGT_TAB[{w_stage_nxt, 1'b0} +: 2];
        end else begin
            w_stage_nxt = 2'd0;
        end
    end

    // ------------------------------------------------------------------------
    // Optional eval_ack timeout
    // ------------------------------------------------------------------------
`ifdef RK4_TIMEOUT_EN
    localparam int c_WAIT_W = $clog2(TIMEOUT + 1);

    logic [c_WAIT_W-1:0] r_wait_cnt;
    logic                r_err;
    logic                w_start_ok;

    assign w_start_ok = (r_state == S_IDLE) && start && !abort;
    // Fires on the TIMEOUT-th consecutive unacknowledged request cycle.
    assign w_timeout  = (r_state == S_EVAL) && !eval_ack &&
                        (r_wait_cnt == c_WAIT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait_cnt <= '0;
            r_err      <= 1'b0;
        end else begin
            // Any cycle outside EVAL or any ack precedes a fresh stage entry.
            if ((r_state != S_EVAL) || eval_ack) begin
                r_wait_cnt <= '0;
            end else begin
                r_wait_cnt <= r_wait_cnt + c_WAIT_W'(1);
            end
            if (w_start_ok) begin
                r_err <= 1'b0;
            end else if (w_timeout && !abort) begin
                r_err <= 1'b1;
            end
        end
    end

    assign err = r_err;
`else
    assign w_timeout = 1'b0;
    assign err       = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign busy       = (r_state != S_IDLE);
    assign eval_req   = (r_state == S_EVAL);
    assign commit     = (r_state == S_COMMIT);
    assign acc_en     = eval_req && eval_ack;
    assign acc_clr    = w_acc_clr;
    assign done       = r_done;
    assign step_cnt   = r_step_cnt;
    assign eval_stage = r_stage;
    assign offs_sel   = r_offs_sel;
    assign acc_w      = r_acc_w;

endmodule

`default_nettype wire

// File: tb/tb_rk4_step_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_rk4_step_sequencer
// Purpose  : Self-checking bench for rk4_step_sequencer. A step-level
//            reference model (phase = idle / stage k / commit) predicts every
//            output each cycle; directed runs add timing and count checks,
//            followed by a randomized start/abort/ack/reset soak.
// Options  : RK4_TIMEOUT_EN - also exercises the eval_ack timeout.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rk4_step_sequencer;

    localparam int STEP_W  = 16;
    localparam int TIMEOUT = 64;

    logic              clk = 1'b0;
    logic              rst, start, abort, eval_ack;
    logic [STEP_W-1:0] n_steps;
    logic              busy, done, eval_req, acc_clr, acc_en, commit, err;
    logic [STEP_W-1:0] step_cnt;
    logic [1:0]        eval_stage, offs_sel, acc_w;

    always #5 clk = ~clk;

    rk4_step_sequencer #(.STEP_W(STEP_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .n_steps(n_steps),
        .busy(busy), .done(done), .step_cnt(step_cnt), .eval_req(eval_req),
        .eval_stage(eval_stage), .offs_sel(offs_sel), .acc_w(acc_w),
        .eval_ack(eval_ack), .acc_clr(acc_clr), .acc_en(acc_en),
        .commit(commit), .err(err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // m_phase: -1 idle, 0..3 evaluating slope k(m_phase+1), 4 commit
    int m_phase, m_cnt, m_n, m_wait;
    bit m_done, m_err, m_valid;
    int offs_tab[4] = '{0, 1, 1, 2};
    int wgt_tab[4]  = '{1, 2, 2, 1};

    task automatic model_update();
        int nph, ncnt, nn, nwait;
        bit ndone, nerr;
        if (rst) begin
            m_phase = -1; m_cnt = 0; m_n = 0; m_wait = 0;
            m_done = 0; m_err = 0; m_valid = 1;
            return;
        end
        nph = m_phase; ncnt = m_cnt; nn = m_n; nerr = m_err; nwait = 0; ndone = 0;
        if (m_phase == -1) begin
            if (start && !abort) begin
                ncnt = 0; nerr = 0;
                if (n_steps == 0) ndone = 1;
                else begin nph = 0; nn = int'(n_steps); end
            end
        end else if (m_phase < 4) begin
            if (abort) nph = -1;
            else if (eval_ack) nph = m_phase + 1;
            else begin
                nwait = m_wait + 1;
`ifdef RK4_TIMEOUT_EN
                if (nwait == TIMEOUT) begin nph = -1; nerr = 1; end
`endif
            end
        end else begin
            ncnt = m_cnt + 1;
            if (abort) nph = -1;
            else if (ncnt == m_n) begin nph = -1; ndone = 1; end
            else nph = 0;
        end
        m_phase = nph; m_cnt = ncnt; m_n = nn; m_wait = nwait;
        m_done = ndone; m_err = nerr;
    endtask

    // ---------------- observation ----------------
    int cyc = 0;
    int commit_cyc[$];
    int done_cyc[$];
    int seen_stage[$], seen_offs[$], seen_wgt[$];
    int n_accen, n_evalreq, n_waitcyc;

    task automatic clear_obs();
        commit_cyc.delete(); done_cyc.delete();
        seen_stage.delete(); seen_offs.delete(); seen_wgt.delete();
        n_accen = 0; n_evalreq = 0; n_waitcyc = 0;
    endtask

    // One clock: inputs are already set (at the falling edge); compare all
    // outputs against the model, record events, then advance the model.
    task automatic tick();
        bit ev;
        int exp_clr;
        #1;
        if (m_valid) begin
            ev = (m_phase >= 0) && (m_phase < 4);
            exp_clr = ((m_phase == -1) && start && !abort && (n_steps != 0)) ||
                      ((m_phase == 4) && !abort && ((m_cnt + 1) != m_n));
            check("busy",       32'(busy),       32'(m_phase != -1));
            check("done",       32'(done),       32'(m_done));
            check("step_cnt",   32'(step_cnt),   32'(m_cnt % (1 << STEP_W)));
            check("eval_req",   32'(eval_req),   32'(ev));
            check("eval_stage", 32'(eval_stage), ev ? 32'(m_phase) : 32'd0);
            check("offs_sel",   32'(offs_sel),   ev ? 32'(offs_tab[m_phase]) : 32'd0);
            check("acc_w",      32'(acc_w),      ev ? 32'(wgt_tab[m_phase]) : 32'd0);
            check("acc_en",     32'(acc_en),     32'(ev && eval_ack));
            check("acc_clr",    32'(acc_clr),    32'(exp_clr));
            check("commit",     32'(commit),     32'(m_phase == 4));
            check("err",        32'(err),        32'(m_err));
        end
        if (commit === 1'b1) commit_cyc.push_back(cyc);
        if (done === 1'b1) done_cyc.push_back(cyc);
        if (eval_req === 1'b1) n_evalreq++;
        if (eval_req === 1'b1 && eval_ack === 1'b0) n_waitcyc++;
        if (acc_en === 1'b1) begin
            n_accen++;
            seen_stage.push_back(int'(eval_stage));
            seen_offs.push_back(int'(offs_sel));
            seen_wgt.push_back(int'(acc_w));
        end
        @(posedge clk);
        model_update();
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        rst = 0; start = 0; abort = 0; eval_ack = 0; n_steps = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        tick(); tick();
        rst = 0;
    endtask

    int c0, wc;

    initial begin
        m_valid = 0; m_phase = -1; m_cnt = 0; m_n = 0; m_wait = 0;
        m_done = 0; m_err = 0;
        clear_obs();
        idle_inputs();
        @(negedge clk);

        // ---- reset then idle ----
        do_reset();
        for (int i = 0; i < 10; i++) tick();
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_step_cnt", 32'(step_cnt), 32'd0);

        // ---- n_steps=3, zero-wait ack ----
        clear_obs();
        c0 = cyc;
        start = 1; n_steps = 16'd3; eval_ack = 1;
        tick();
        start = 0;
        for (int i = 0; i < 30 && m_phase != -1; i++) tick();
        tick();
        check("s3_commits", commit_cyc.size(), 3);
        for (int i = 0; i < commit_cyc.size() && i < 3; i++)
            check("s3_commit_cyc", commit_cyc[i] - c0, 5 * (i + 1));
        check("s3_done_cnt", done_cyc.size(), 1);
        if (done_cyc.size() > 0) check("s3_done_cyc", done_cyc[0] - c0, 16);
        check("s3_stage_cnt", seen_stage.size(), 12);
        for (int i = 0; i < seen_stage.size() && i < 12; i++) begin
            check("s3_stage_seq", seen_stage[i], i % 4);
            check("s3_offs_seq", seen_offs[i], offs_tab[i % 4]);
            check("s3_wgt_seq", seen_wgt[i], wgt_tab[i % 4]);
        end
        check("s3_step_cnt", 32'(step_cnt), 32'd3);

        // ---- n_steps=2, ack after 3 wait cycles per stage ----
        clear_obs();
        eval_ack = 0; start = 1; n_steps = 16'd2;
        tick();
        start = 0; wc = 0;
        for (int i = 0; i < 80 && m_phase != -1; i++) begin
            eval_ack = (m_phase >= 0 && m_phase < 4 && wc == 3);
            if (m_phase >= 0 && m_phase < 4) wc = eval_ack ? 0 : wc + 1;
            tick();
        end
        eval_ack = 0;
        tick();
        check("d2_accen", n_accen, 8);
        check("d2_commits", commit_cyc.size(), 2);
        check("d2_done", done_cyc.size(), 1);
        check("d2_waits", n_waitcyc, 24);

        // ---- n_steps=0, and start+abort in IDLE ----
        clear_obs();
        start = 1; n_steps = 16'd0;
        tick();
        start = 0;
        for (int i = 0; i < 5; i++) tick();
        check("z_done", done_cyc.size(), 1);
        if (done_cyc.size() > 0) check("z_done_cyc", done_cyc[0] - (cyc - 6), 1);
        check("z_evalreq", n_evalreq, 0);
        clear_obs();
        start = 1; abort = 1; n_steps = 16'd4;
        tick();
        start = 0; abort = 0;
        for (int i = 0; i < 5; i++) tick();
        check("sa_busy", n_evalreq + done_cyc.size(), 0);

        // ---- n_steps=5, start while busy, abort at step 3 stage 2 ----
        clear_obs();
        c0 = cyc;
        start = 1; n_steps = 16'd5; eval_ack = 1;
        tick();
        start = 0;
        for (int k = 1; k <= 13; k++) begin
            start = (k == 3);
            n_steps = (k == 3) ? 16'd1 : 16'd5;
            abort = (k == 13);
            if (k == 13) check("ab_stage_at_abort", 32'(eval_stage), 32'd2);
            tick();
        end
        start = 0; abort = 0; eval_ack = 0;
        check("ab_busy", 32'(busy), 32'd0);
        check("ab_step_cnt", 32'(step_cnt), 32'd2);
        for (int i = 0; i < 4; i++) tick();
        check("ab_no_done", done_cyc.size(), 0);

        // ---- abort in the COMMIT cycle still counts the commit ----
        clear_obs();
        start = 1; n_steps = 16'd3; eval_ack = 1;
        tick();
        start = 0;
        for (int k = 1; k <= 5; k++) begin
            abort = (k == 5);
            tick();
        end
        abort = 0; eval_ack = 0;
        check("abc_step_cnt", 32'(step_cnt), 32'd1);
        check("abc_busy", 32'(busy), 32'd0);

`ifdef RK4_TIMEOUT_EN
        // ---- timeout: ack withheld at stage 1 ----
        clear_obs();
        start = 1; n_steps = 16'd2;
        tick();
        start = 0;
        for (int i = 0; i < 200 && m_phase != -1; i++) begin
            eval_ack = (m_phase != 1);
            tick();
        end
        eval_ack = 0;
        tick();
        check("to_err", 32'(err), 32'd1);
        check("to_busy", 32'(busy), 32'd0);
        check("to_no_done", done_cyc.size(), 0);
        check("to_waits", n_waitcyc, TIMEOUT);
        start = 1; n_steps = 16'd1; eval_ack = 1;
        tick();
        start = 0;
        check("to_err_clr", 32'(err), 32'd0);
        for (int i = 0; i < 8; i++) tick();
        eval_ack = 0;
`endif

        // ---- randomized soak ----
        for (int i = 0; i < 2000; i++) begin
            rst      = ($urandom_range(0, 399) == 0);
            start    = ($urandom_range(0, 7) == 0);
            n_steps  = STEP_W'($urandom_range(0, 4));
            abort    = ($urandom_range(0, 29) == 0);
            eval_ack = ($urandom_range(0, 3) != 0);
            tick();
        end
        idle_inputs();

        // ---- reset mid-run ----
        start = 1; n_steps = 16'd4; eval_ack = 1;
        tick();
        start = 0;
        for (int i = 0; i < 7; i++) tick();
        rst = 1;
        tick();
        rst = 0; eval_ack = 0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_step_cnt", 32'(step_cnt), 32'd0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
